// File: rtl/am_err_accum_if.sv
// am_err_accum_if: sample stream and result bus of the approximate-multiplier
// error accumulator. The master drives samples and start; the slave (the
// accumulator) drives handshake status and the running error metrics.
interface am_err_accum_if #(
    parameter int ACC_W = 48
) ();
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       x;
    logic [7:0]       y;
    logic [15:0]      z;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] sse;
    logic [ACC_W-1:0] sae;
    logic [15:0]      max_ed;
    logic [20:0]      err_cnt;
    logic [ACC_W-1:0] sum_err;

    modport master (
        output start, in_valid, x, y, z,
        input  in_ready, busy, done, sse, sae, max_ed, err_cnt, sum_err
    );

    modport slave (
        input  start, in_valid, x, y, z,
        output in_ready, busy, done, sse, sae, max_ed, err_cnt, sum_err
    );
endinterface

// File: rtl/am_err_accum.sv
// am_err_accum: streaming error-metric accumulator for an unsigned 8x8
// approximate multiplier. Each accepted sample (x, y, z) yields
// e = z - x*y; over a run of N_SAMPLES the block accumulates sum e^2 and
// sum |e| (both saturating), max |e| and the count of nonzero errors.
// Three-stage datapath: S1 captures operands, S2 forms e, |e| and e^2,
// S3 accumulates. A run is IDLE/DONE -> RUN -> DRAIN (3 cycles) -> DONE.
// Optional feature: define AM_ERR_SIGNED_SUM_EN to build the wrapping
// signed bias accumulator sum_err; otherwise sum_err is tied to zero.
module am_err_accum #(
    parameter int N_SAMPLES = 65536,
    parameter int ACC_W     = 48
) (
    input logic           clk,
    input logic           rst_n,
    am_err_accum_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Accept counter must hold the value N_SAMPLES itself.
    localparam int CNT_W = $clog2(N_SAMPLES + 1);
    // Sum widths wide enough that the carry out of ACC_W is never lost,
    // even when the addend is wider than the accumulator.
    localparam int SSE_W = ((ACC_W > 32) ? ACC_W : 32) + 1;
    localparam int SAE_W = ((ACC_W > 16) ? ACC_W : 16) + 1;

    localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_SAMPLES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);
    localparam logic [1:0]       DRAIN_LAST = 2'd2;

    // ------------------------------------------------------------------
    // Run controller
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [1:0]       drain_cnt_q, drain_cnt_d;

    logic accept;
    logic last_accept;
    logic clear;

    assign bus.in_ready = (state_q == S_RUN) && (acc_cnt_q < N_CNT);
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_accept  = accept && (acc_cnt_q == LAST_IDX);
    // start only takes effect when no run is in flight.
    assign clear        = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

    assign bus.busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.done = (state_q == S_DONE);

    // Next-state logic: run sequencing and the DRAIN timer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        acc_cnt_d   = acc_cnt_q;
        drain_cnt_d = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_accept) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 2'd1;
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (clear) begin
            acc_cnt_d = '0;
        end else if (accept) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end
    end

    // Controller registers: state, accept counter and drain timer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_cnt_q   <= '0;
            drain_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // S1: operand capture
    // ------------------------------------------------------------------
    logic        s1_valid_q;
    logic [7:0]  s1_x_q;
    logic [7:0]  s1_y_q;
    logic [15:0] s1_z_q;

    // S1 valid bit: only accepted samples enter the pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
        end
    end

    // S1 operand registers, loaded on accept.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; the valid bits alone decide whether their contents are used.
        if (accept) begin
            s1_x_q <= bus.x;
            s1_y_q <= bus.y;
            s1_z_q <= bus.z;
        end
    end

    // ------------------------------------------------------------------
    // S2: exact product, signed error, magnitude and square
    // ------------------------------------------------------------------
    logic [15:0]        prod;
    logic signed [16:0] err;
    logic [15:0]        abs_err;
    logic [31:0]        sq_err;

    // Error terms of the sample held in S1.
    always_comb begin
        prod    = 16'(s1_x_q) * 16'(s1_y_q);
        err     = $signed({1'b0, s1_z_q}) - $signed({1'b0, prod});
        abs_err = err[16] ? 16'(-err) : err[15:0];
        sq_err  = 32'(abs_err) * 32'(abs_err);
    end

    logic        s2_valid_q;
    logic [15:0] s2_abs_q;
    logic [31:0] s2_sq_q;

    // S2 valid bit follows S1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
        end
    end

    // S2 error registers.
    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            s2_abs_q <= abs_err;
            s2_sq_q  <= sq_err;
        end
    end

    // ------------------------------------------------------------------
    // S3: accumulation
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] sse_q, sse_d;
    logic [ACC_W-1:0] sae_q, sae_d;
    logic [15:0]      max_ed_q, max_ed_d;
    logic [20:0]      err_cnt_q, err_cnt_d;
    logic [SSE_W-1:0] sse_sum;
    logic [SAE_W-1:0] sae_sum;

    // Saturating sums, running maximum and nonzero-error count.
    always_comb begin
        sse_sum   = SSE_W'(sse_q) + SSE_W'(s2_sq_q);
        sae_sum   = SAE_W'(sae_q) + SAE_W'(s2_abs_q);
        sse_d     = sse_q;
        sae_d     = sae_q;
        max_ed_d  = max_ed_q;
        err_cnt_d = err_cnt_q;

        if (clear) begin
            sse_d     = '0;
            sae_d     = '0;
            max_ed_d  = 16'd0;
            err_cnt_d = 21'd0;
        end else if (s2_valid_q) begin
            // Any carry above ACC_W clamps to all-ones; once clamped, every
            // later add carries again, so the value sticks for the run.
            sse_d = (|sse_sum[SSE_W-1:ACC_W]) ? '1 : sse_sum[ACC_W-1:0];
            sae_d = (|sae_sum[SAE_W-1:ACC_W]) ? '1 : sae_sum[ACC_W-1:0];
            if (s2_abs_q > max_ed_q) begin
                max_ed_d = s2_abs_q;
            end
            if (s2_abs_q != 16'd0) begin
                err_cnt_d = err_cnt_q + 21'd1;
            end
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sse_q     <= '0;
            sae_q     <= '0;
            max_ed_q  <= 16'd0;
            err_cnt_q <= 21'd0;
        end else begin
            sse_q     <= sse_d;
            sae_q     <= sae_d;
            max_ed_q  <= max_ed_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.sse     = sse_q;
    assign bus.sae     = sae_q;
    assign bus.max_ed  = max_ed_q;
    assign bus.err_cnt = err_cnt_q;

    // ------------------------------------------------------------------
    // Optional signed bias accumulator
    // ------------------------------------------------------------------
`ifdef AM_ERR_SIGNED_SUM_EN
    logic             s2_neg_q;
    logic [ACC_W-1:0] sum_err_q, sum_err_d;

    // Sign of the S2 error, kept alongside its magnitude.
    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            s2_neg_q <= err[16];
        end
    end

    // Wrapping two's-complement sum of e; adding or subtracting |e| modulo
    // 2^ACC_W equals adding the sign-extended e.
    always_comb begin
        sum_err_d = sum_err_q;
        if (clear) begin
            sum_err_d = '0;
        end else if (s2_valid_q) begin
            sum_err_d = s2_neg_q ? (sum_err_q - ACC_W'(s2_abs_q))
                                 : (sum_err_q + ACC_W'(s2_abs_q));
        end
    end

    // Bias accumulator register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_err_q <= '0;
        end else begin
            sum_err_q <= sum_err_d;
        end
    end

    assign bus.sum_err = sum_err_q;
`else
    assign bus.sum_err = '0;
`endif

endmodule

// File: tb/tb_am_err_accum.sv
// tb_am_err_accum: self-checking bench for am_err_accum. Five DUT instances
// with different N_SAMPLES / ACC_W share the sample stream; each is started
// individually. Directed runs come from a vector table, randomized runs are
// checked against a plain-arithmetic model of the error metrics.
module tb_am_err_accum;

    localparam int NDUT = 5;

    function automatic int ns_of(input int g);
        case (g)
            0:       return 16;
            1:       return 4;
            2:       return 2;
            3:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic int aw_of(input int g);
        return (g == 4) ? 8 : 48;
    endfunction

    logic        clk;
    logic        rst_n;
    logic        start_s [NDUT];
    logic        valid_s;
    logic [7:0]  x_s;
    logic [7:0]  y_s;
    logic [15:0] z_s;

    logic        rdy_v  [NDUT];
    logic        busy_v [NDUT];
    logic        done_v [NDUT];
    logic [63:0] sse_v  [NDUT];
    logic [63:0] sae_v  [NDUT];
    logic [63:0] sum_v  [NDUT];
    logic [15:0] max_v  [NDUT];
    logic [20:0] cnt_v  [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int AW = aw_of(g);
        am_err_accum_if #(.ACC_W(AW)) bus ();

        assign bus.start    = start_s[g];
        assign bus.in_valid = valid_s;
        assign bus.x        = x_s;
        assign bus.y        = y_s;
        assign bus.z        = z_s;

        am_err_accum #(.N_SAMPLES(ns_of(g)), .ACC_W(AW)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign rdy_v[g]  = bus.in_ready;
        assign busy_v[g] = bus.busy;
        assign done_v[g] = bus.done;
        assign sse_v[g]  = 64'(bus.sse);
        assign sae_v[g]  = 64'(bus.sae);
        assign sum_v[g]  = 64'($signed(bus.sum_err));
        assign max_v[g]  = bus.max_ed;
        assign cnt_v[g]  = bus.err_cnt;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  qx [$];
    logic [7:0]  qy [$];
    logic [15:0] qz [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference metrics from the sample queues, straight from the definitions.
    function automatic void model(input int aw, output logic [63:0] esse, output logic [63:0] esae,
                                  output logic [63:0] emax, output logic [63:0] ecnt,
                                  output logic [63:0] esum);
        longint unsigned cap;
        longint unsigned s;
        longint unsigned a;
        longint          sm;
        int              e;
        int              ae;
        int              mx;
        int              c;
        cap = (aw >= 64) ? {64{1'b1}} : ((64'd1 << aw) - 64'd1);
        s = 0; a = 0; sm = 0; mx = 0; c = 0;
        foreach (qx[i]) begin
            e  = int'(qz[i]) - int'(qx[i]) * int'(qy[i]);
            ae = (e < 0) ? -e : e;
            s  = s + longint'(ae) * longint'(ae);
            if (s > cap) s = cap;
            a  = a + longint'(ae);
            if (a > cap) a = cap;
            if (ae > mx) mx = ae;
            if (e != 0) c++;
            sm = sm + longint'(e);
        end
        esse = s;
        esae = a;
        emax = 64'(mx);
        ecnt = 64'(c);
`ifdef AM_ERR_SIGNED_SUM_EN
        esum = 64'(sm);
        if (aw < 64) begin
            esum = esum & cap;
            if (esum[aw-1]) esum = esum | ~cap;
        end
`else
        esum = 64'd0;
`endif
    endfunction

    task automatic check_model(input int k, input string tag);
        logic [63:0] es, ea, em, ec, esum;
        model(aw_of(k), es, ea, em, ec, esum);
        check({tag, " sse"},     sse_v[k], es);
        check({tag, " sae"},     sae_v[k], ea);
        check({tag, " max_ed"},  64'(max_v[k]), em);
        check({tag, " err_cnt"}, 64'(cnt_v[k]), ec);
        check({tag, " sum_err"}, sum_v[k], esum);
    endtask

    // All tasks begin and end at a falling edge.
    task automatic pulse_start(input int k);
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
    endtask

    task automatic send(input int k, input logic [7:0] xx, input logic [7:0] yy,
                        input logic [15:0] zz, output bit ok);
        x_s = xx; y_s = yy; z_s = zz; valid_s = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rdy_v[k]) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        valid_s = 1'b0;
    endtask

    // Start instance k, stream the queued samples, then hold junk valid
    // samples through DRAIN and measure the final-accept-to-done latency.
    task automatic run_queue(input int k, input bit gaps, input bit start_late, input string tag);
        bit ok;
        int lat;
        int n;
        n = qx.size();
        pulse_start(k);
        check({tag, " cleared sse"},     sse_v[k], 64'd0);
        check({tag, " cleared err_cnt"}, 64'(cnt_v[k]), 64'd0);
        check({tag, " cleared max_ed"},  64'(max_v[k]), 64'd0);
        check({tag, " ready after start"}, 64'(rdy_v[k]), 64'd1);
        check({tag, " done low in run"},   64'(done_v[k]), 64'd0);
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                valid_s = 1'b0;
                repeat (2) @(negedge clk);
            end
            if (start_late && i == n - 1) start_s[k] = 1'b1;
            send(k, qx[i], qy[i], qz[i], ok);
            if (!ok) check({tag, " accept timeout"}, 64'd0, 64'd1);
        end
        check({tag, " ready low after last"}, 64'(rdy_v[k]), 64'd0);
        check({tag, " busy in drain"},        64'(busy_v[k]), 64'd1);
        valid_s = 1'b1; x_s = 8'd1; y_s = 8'd1; z_s = 16'd100;
        lat = 0;
        while (!done_v[k] && lat < 20) begin
            @(negedge clk);
            start_s[k] = 1'b0;
            lat++;
        end
        valid_s = 1'b0;
        start_s[k] = 1'b0;
        check({tag, " done latency"}, 64'(lat), 64'd3);
        check({tag, " busy low in done"}, 64'(busy_v[k]), 64'd0);
    endtask

    typedef struct {
        string       name;
        int          inst;
        int          n;
        bit          gaps;
        bit          start_late;
        logic [7:0]  x0, y0;
        logic [15:0] z0;
        logic [7:0]  x1, y1;
        logic [15:0] z1;
        logic [63:0] sse;
        logic [63:0] sae;
        logic [63:0] max_ed;
        logic [63:0] cnt;
        logic [63:0] sum;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        logic [15:0] zz;
        logic [63:0] exp_sum;

        // Even-indexed samples use (x0,y0,z0), odd ones (x1,y1,z1).
        tbl[0] = '{"bias",    1, 4, 1'b0, 1'b0, 8'd10, 8'd20, 16'd203, 8'd7, 8'd9, 16'd66,
                   64'd36, 64'd12, 64'd3, 64'd4, 64'd12};
        tbl[1] = '{"negext",  2, 2, 1'b0, 1'b1, 8'd255, 8'd255, 16'd65000, 8'd0, 8'd0, 16'd0,
                   64'd625, 64'd25, 64'd25, 64'd1, 64'hFFFF_FFFF_FFFF_FFE7};
        tbl[2] = '{"satur",   4, 2, 1'b0, 1'b0, 8'd4, 8'd4, 16'd32, 8'd3, 8'd3, 16'd10,
                   64'd255, 64'd17, 64'd16, 64'd2, 64'd17};
        tbl[3] = '{"gaps",    3, 8, 1'b1, 1'b0, 8'd5, 8'd6, 16'd29, 8'd200, 8'd100, 16'd20000,
                   64'd4, 64'd4, 64'd1, 64'd4, 64'hFFFF_FFFF_FFFF_FFFC};
        tbl[4] = '{"nogaps",  3, 8, 1'b0, 1'b0, 8'd5, 8'd6, 16'd29, 8'd200, 8'd100, 16'd20000,
                   64'd4, 64'd4, 64'd1, 64'd4, 64'hFFFF_FFFF_FFFF_FFFC};

        rst_n = 1'b0;
        valid_s = 1'b0;
        x_s = '0; y_s = '0; z_s = '0;
        for (int k = 0; k < NDUT; k++) start_s[k] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("reset%0d ready", k), 64'(rdy_v[k]), 64'd0);
            check($sformatf("reset%0d busy", k),  64'(busy_v[k]), 64'd0);
            check($sformatf("reset%0d done", k),  64'(done_v[k]), 64'd0);
            check($sformatf("reset%0d sse", k),   sse_v[k], 64'd0);
            check($sformatf("reset%0d cnt", k),   64'(cnt_v[k]), 64'd0);
        end

        // Directed vectors.
        for (int t = 0; t < 5; t++) begin
            qx.delete(); qy.delete(); qz.delete();
            for (int i = 0; i < tbl[t].n; i++) begin
                qx.push_back((i % 2 == 0) ? tbl[t].x0 : tbl[t].x1);
                qy.push_back((i % 2 == 0) ? tbl[t].y0 : tbl[t].y1);
                qz.push_back((i % 2 == 0) ? tbl[t].z0 : tbl[t].z1);
            end
            run_queue(tbl[t].inst, tbl[t].gaps, tbl[t].start_late, tbl[t].name);
`ifdef AM_ERR_SIGNED_SUM_EN
            exp_sum = tbl[t].sum;
`else
            exp_sum = 64'd0;
`endif
            check({tbl[t].name, " sse"},     sse_v[tbl[t].inst], tbl[t].sse);
            check({tbl[t].name, " sae"},     sae_v[tbl[t].inst], tbl[t].sae);
            check({tbl[t].name, " max_ed"},  64'(max_v[tbl[t].inst]), tbl[t].max_ed);
            check({tbl[t].name, " err_cnt"}, 64'(cnt_v[tbl[t].inst]), tbl[t].cnt);
            check({tbl[t].name, " sum_err"}, sum_v[tbl[t].inst], exp_sum);
            check({tbl[t].name, " done held"}, 64'(done_v[tbl[t].inst]), 64'd1);
        end

        // Randomized runs on the N_SAMPLES=16 instance.
        for (int r = 0; r < 5; r++) begin
            qx.delete(); qy.delete(); qz.delete();
            for (int i = 0; i < 16; i++) begin
                a = 8'($urandom);
                b = 8'($urandom);
                p = 16'(a) * 16'(b);
                case (r)
                    0:       zz = p;
                    1:       zz = 16'($urandom);
                    2:       zz = p ^ 16'($urandom_range(0, 15));
                    3:       zz = p & 16'hFFF0;
                    default: zz = 16'(p + 16'($urandom_range(0, 600)) - 16'd300);
                endcase
                qx.push_back(a); qy.push_back(b); qz.push_back(zz);
            end
            run_queue(0, (r == 3), (r == 2), $sformatf("rand%0d", r));
            check_model(0, $sformatf("rand%0d", r));
            if (r == 0) begin
                check("exact sse zero", sse_v[0], 64'd0);
                check("exact err_cnt zero", 64'(cnt_v[0]), 64'd0);
            end
        end

        // Reset in the middle of a run discards everything in flight.
        begin
            bit ok;
            pulse_start(0);
            for (int i = 0; i < 5; i++) begin
                send(0, 8'(i + 3), 8'd7, 16'd5000, ok);
                if (!ok) check("midreset accept timeout", 64'd0, 64'd1);
            end
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("midreset ready", 64'(rdy_v[0]), 64'd0);
            check("midreset busy",  64'(busy_v[0]), 64'd0);
            check("midreset done",  64'(done_v[0]), 64'd0);
            check("midreset sse",   sse_v[0], 64'd0);
            check("midreset sae",   sae_v[0], 64'd0);
            check("midreset max_ed", 64'(max_v[0]), 64'd0);
            check("midreset err_cnt", 64'(cnt_v[0]), 64'd0);
            repeat (3) @(negedge clk);
            check("midreset pipeline flushed sae", sae_v[0], 64'd0);
            check("midreset stays idle", 64'(rdy_v[0]), 64'd0);
        end

        // Recovery run after the reset.
        qx.delete(); qy.delete(); qz.delete();
        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            qx.push_back(a); qy.push_back(b); qz.push_back(16'($urandom));
        end
        run_queue(0, 1'b0, 1'b0, "recover");
        check_model(0, "recover");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
